// File: rtl/serial_sub_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial subtract sequencer. A single 1-bit full-subtractor cell is
// reused once per clock, walking LSB-first across a WIDTH-bit operand
// pair. It computes diff = a - b (modulo 2^WIDTH) and the final borrow.
// This gives a multi-bit subtract that needs only one cell of arithmetic,
// at the cost of WIDTH cycles of latency.
//
// Handshake:
//   - Operands are accepted on a clock edge where in_valid=1 and
//     in_ready=1. in_ready is high only in IDLE.
//   - The result is presented with out_valid=1 in DONE. It is released
//     on an edge where out_ready=1.
//
// Latency and throughput:
//   - out_valid rises exactly WIDTH edges after the accepting edge.
//   - The block produces at most one result every WIDTH+2 cycles.
//
// Parameters:
//   WIDTH      operand and result width in bits, legal range 2..32
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   an operand pair is presented on a/b
//   in_ready   the block can accept operands (IDLE only)
//   a          minuend
//   b          subtrahend
//   out_valid  diff/bow hold a completed result (DONE)
//   out_ready  the consumer accepts the result
//   diff       a - b modulo 2^WIDTH; held until the next result completes
//   bow        final borrow, 1 when a < b (unsigned)
//   busy       high while the serial subtract is running
//   ovf        signed two's-complement overflow of a - b.
//              This port exists only when SERIAL_SUB_OVF_EN is defined.
//
// Build option:
//   SERIAL_SUB_OVF_EN  adds the ovf output and its register.
// ----------------------------------------------------------------------------
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bow,
   output logic             busy
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Bit-counter width. The counter only ever holds 0..WIDTH-1. It is
   // cleared on the last RUN edge, so it never wraps.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   // Operand shift registers. Each one shifts right, so bit 0 always
   // holds the bit that the subtractor cell is working on.
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;

   // Partial result. Each difference bit enters from the MSB side, so
   // after WIDTH shifts bit i of the result is at position i.
   logic [WIDTH-1:0] res;

   logic             br;       // borrow carried between bit positions
   logic [CW-1:0]    cnt;      // index of the bit being processed

   logic             d_bit;    // difference bit from the cell
   logic             br_nxt;   // borrow out of the cell
   logic             last_bit; // this RUN edge processes the MSB

   // ------------------------------------------------------------------
   // The one full-subtractor cell.
   // ------------------------------------------------------------------
   always_comb begin
      d_bit    = sh_a[0] ^ sh_b[0] ^ br;
      br_nxt   = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
      last_bit = (cnt == LAST);
   end

   // ------------------------------------------------------------------
   // FSM state register.
   // ------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments. All flops then
   //       sample their pre-edge values, whatever order the simulator
   //       evaluates the processes in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic and output decode. The handshake outputs depend
   // only on the registered state, so they are free of glitches from
   // the input side.
   // ------------------------------------------------------------------
   // NOTE: every output of this block gets a default first. Then no
   //       path leaves a signal unassigned, and no latch is inferred.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Serial datapath.
   //   - diff and bow are written only on the last RUN edge. They
   //     therefore keep the previous result through IDLE and the next
   //     RUN.
   //   - A reset in the middle of a run discards the partial result.
   // ------------------------------------------------------------------
   // NOTE: every datapath register is reset, including the shift
   //       registers. This guarantees that no X reaches diff/bow after
   //       reset, whatever is driven on a/b.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a <= '0;
         sh_b <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bow  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh_a <= a;
                  sh_b <= b;
                  res  <= '0;
                  br   <= 1'b0;
                  cnt  <= '0;
               end
            end
            RUN: begin
               sh_a <= sh_a >> 1;
               sh_b <= sh_b >> 1;
               br   <= br_nxt;
               res  <= {d_bit, res[WIDTH-1:1]};
               if (last_bit) begin
                  cnt  <= '0;
                  diff <= {d_bit, res[WIDTH-1:1]};
                  bow  <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                  // On this edge bit 0 of each shift register holds the
                  // operand sign bit, and d_bit is the result sign bit.
                  // Overflow means the operand signs differ and the result
                  // sign differs from the minuend sign.
                  ovf  <= (sh_a[0] ^ sh_b[0]) & (d_bit ^ sh_a[0]);
`endif
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Scoreboard bench for serial_sub_ctrl at WIDTH=8.
//   - The driver pushes the expected result of each accepted pair into
//     a queue. That result comes from plain integer arithmetic.
//   - An independent monitor pops one entry each time out_valid rises.
//     It compares diff, bow (and ovf, when enabled) and the latency.
//   - Directed scenarios are followed by a randomized sweep with random
//     out_ready stalls.
// ----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

   localparam int  W = 8;
   localparam time P = 10;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] diff;
   logic         bow;
   logic         busy;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bow       (bow),
      .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #(P/2) clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // --------------------------------------------------------------------
   // Reference model: plain arithmetic on the operand values.
   // --------------------------------------------------------------------
   typedef struct {
      logic [W-1:0] d;
      logic         bw;
      logic         ov;
      time          t_acc;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] last_d = '0;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input time t);
      exp_t   e;
      longint ux  = longint'(x);
      longint uy  = longint'(y);
      longint m   = longint'(1) << W;
      longint sx  = (ux >= m / 2) ? ux - m : ux;
      longint sy  = (uy >= m / 2) ? uy - m : uy;
      longint sr  = sx - sy;
      longint dif = (ux - uy + m) % m;
      e.d     = dif[W-1:0];
      e.bw    = (ux < uy);
      e.ov    = (sr > m / 2 - 1) || (sr < -(m / 2));
      e.t_acc = t;
      return e;
   endfunction

   // --------------------------------------------------------------------
   // Monitor: each new result is checked against the oldest expectation.
   // --------------------------------------------------------------------
   logic mon_prev = 1'b0;

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (out_valid && !mon_prev) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: out_valid rose with diff=0x%0h, no result expected", diff);
            end else begin
               e = sb_q.pop_front();
               last_d = e.d;
               check("diff", diff, e.d);
               check("bow", bow, e.bw);
`ifdef SERIAL_SUB_OVF_EN
               check("ovf", ovf, e.ov);
`endif
               check("latency", ($time - 1 - e.t_acc) / P, W);
            end
         end
         mon_prev = out_valid;
      end
   end

   // --------------------------------------------------------------------
   // Driver tasks
   // --------------------------------------------------------------------
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
         return;
      end
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back(model(x, y, $time));
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input bit stall);
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (out_valid) begin
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_ready) begin
               @(posedge clk);
               #1;
               out_ready = 1'b0;
               done      = 1'b1;
               check("hs_out_valid_low", out_valid, 1'b0);
               check("hs_in_ready", in_ready, 1'b1);
               check("hs_diff_hold", diff, last_d);
            end
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: no result handshake within 300 cycles");
      end
   endtask

   task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input bit stall);
      issue(x, y);
      drain(stall);
   endtask

   // --------------------------------------------------------------------
   // Watchdog
   // --------------------------------------------------------------------
   initial begin
      #(P * 90000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------------------
   // Main sequence
   // --------------------------------------------------------------------
   initial begin
      int n_busy;
      bit seen;

      // Reset, then idle.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_diff", diff, 8'h00);
      check("rst_bow", bow, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("idle_hold", {in_ready, out_valid, busy, bow, diff}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      end

      // Basic subtract, with busy counted over the run.
      out_ready = 1'b0;
      issue(8'h05, 8'h03);
      n_busy = 0;
      seen   = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (busy) n_busy++;
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("busy_cycles", n_busy, W);
      drain(1'b0);

      // Borrow and wrap-around.
      run_one(8'h03, 8'h05, 1'b0);
      run_one(8'h00, 8'hFF, 1'b0);
      run_one(8'hFF, 8'hFF, 1'b0);

      // Backpressure, plus operands presented while not in IDLE.
      out_ready = 1'b0;
      issue(8'hA0, 8'h0F);
      @(negedge clk);
      a        = 8'h11;
      b        = 8'h00;
      in_valid = 1'b1;
      check("run_in_ready", in_ready, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_diff", diff, 8'h91);
         check("bp_bow", bow, 1'b0);
         check("bp_in_ready", in_ready, 1'b0);
         in_valid = (i == 3);
         a        = 8'h11;
         @(negedge clk);
      end
      in_valid = 1'b0;
      drain(1'b0);

      // Reset in the middle of a run.
      issue(8'h55, 8'h22);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("abort_busy", busy, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_diff", diff, 8'h00);
      check("abort_bow", bow, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_one(8'h10, 8'h01, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
      run_one(8'h80, 8'h01, 1'b0);
      run_one(8'h7F, 8'hFF, 1'b0);
      run_one(8'h05, 8'h03, 1'b0);
`endif

      // Randomized sweep with consumer stalls.
      for (int i = 0; i < 1000; i++) begin
         run_one(W'($urandom), W'($urandom), 1'b1);
      end

      @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
